// File: rtl/eq_qpsk_demapper.sv
// Hard-decision QPSK demapper with a two-slot ping-pong symbol buffer and
// valid/ready beat output. Optional drop counter: define EQ_DEMAP_DROPCNT_EN.
module eq_qpsk_demapper #(
  parameter int FFT      = 64,
  parameter int DW       = 32,
  parameter int LANES    = 16,
  parameter int DATASYMS = 12
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [DW*FFT-1:0]             eq_datare_i,
  input  logic [DW*FFT-1:0]             eq_dataim_i,
  input  logic [FFT-1:0]                eq_valid_i,
  input  logic                          m_ready_i,
  output logic [2*LANES-1:0]            bits_o,
  output logic [LANES-1:0]              lane_mask_o,
  output logic                          bits_valid_o,
  output logic [$clog2(FFT/LANES)-1:0]  beat_idx_o,
  output logic [$clog2(DATASYMS)-1:0]   sym_idx_o,
  output logic                          frame_last_o,
  output logic                          overflow_o,
  output logic [7:0]                    drop_cnt_o
);

  localparam int NBEAT = FFT / LANES;
  localparam int BW    = $clog2(NBEAT);
  localparam int SW    = $clog2(DATASYMS);

  typedef enum logic [1:0] {S_EMPTY, S_FULL, S_STREAM} slot_st_e;

  slot_st_e             st_q [2];
  slot_st_e             st_d [2];
  logic                 wr_q, wr_d, hd_q, hd_d;
  // Only the sign bits decide the demapped bits, so only they are stored.
  logic [FFT-1:0]       sre_q [2];
  logic [FFT-1:0]       sim_q [2];
  logic [FFT-1:0]       msk_q [2];
  logic [FFT-1:0]       in_re, in_im;
  logic [FFT-1:0]       src_re, src_im, src_msk;
  logic [FFT-1:0]       sh_re, sh_im, sh_msk;

  logic [2*LANES-1:0]   bits_q, bits_d;
  logic [LANES-1:0]     mask_q, mask_d;
  logic                 valid_q, valid_d;
  logic [BW-1:0]        beat_q, beat_d;
  logic [SW-1:0]        sym_q, sym_d;
  logic                 flast_q, flast_d;
  logic                 ovf_q, ovf_d;

  logic                 cap, accept, last, wen, load, drop;

  logic                 unused_lsbs;
  assign unused_lsbs = ^{eq_datare_i, eq_dataim_i};

  always_comb begin
    in_re = '0;
    in_im = '0;
    for (int unsigned k = 0; k < FFT; k++) begin
      in_re[k] = eq_datare_i[(k+1)*DW-1];
      in_im[k] = eq_dataim_i[(k+1)*DW-1];
    end
  end

  always_comb begin
    cap     = |eq_valid_i;
    accept  = valid_q & m_ready_i;
    last    = accept & (beat_q == BW'(NBEAT-1));
    st_d    = st_q;
    wr_d    = wr_q;
    hd_d    = hd_q;
    sym_d   = sym_q;
    ovf_d   = ovf_q;
    wen     = 1'b0;
    drop    = 1'b0;
    load    = 1'b0;
    valid_d = valid_q;
    beat_d  = beat_q;
    bits_d  = bits_q;
    mask_d  = mask_q;

    // Release is applied before capture so a same-edge capture can reuse the slot.
    if (last) begin
      st_d[hd_q] = S_EMPTY;
      hd_d       = ~hd_q;
      sym_d      = (sym_q == SW'(DATASYMS-1)) ? '0 : sym_q + SW'(1);
    end

    if (cap) begin
      if (st_d[wr_q] == S_EMPTY) begin
        st_d[wr_q] = S_FULL;
        wen        = 1'b1;
        wr_d       = ~wr_q;
      end else begin
        ovf_d = 1'b1;
        drop  = 1'b1;
      end
    end

    if (!valid_q || accept) begin
      if (accept && !last) begin
        beat_d = beat_q + BW'(1);
        load   = 1'b1;
      end else begin
        beat_d = '0;
        if (st_d[hd_d] == S_FULL) begin
          st_d[hd_d] = S_STREAM;
          load       = 1'b1;
        end
      end
      valid_d = load;
      bits_d  = '0;
      mask_d  = '0;
    end

    // A slot written on this same edge is read straight from the inputs.
    if (wen && (wr_q == hd_d)) begin
      src_re  = in_re;
      src_im  = in_im;
      src_msk = eq_valid_i;
    end else begin
      src_re  = sre_q[hd_d];
      src_im  = sim_q[hd_d];
      src_msk = msk_q[hd_d];
    end
    sh_re  = src_re  >> (LANES * int'(beat_d));
    sh_im  = src_im  >> (LANES * int'(beat_d));
    sh_msk = src_msk >> (LANES * int'(beat_d));

    if (load) begin
      for (int unsigned j = 0; j < LANES; j++) begin
        mask_d[j]     = sh_msk[j];
        bits_d[2*j]   = sh_msk[j] & sh_re[j];
        bits_d[2*j+1] = sh_msk[j] & sh_im[j];
      end
    end

    flast_d = valid_d & (sym_d == SW'(DATASYMS-1)) & (beat_d == BW'(NBEAT-1));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q[0] <= S_EMPTY;
      st_q[1] <= S_EMPTY;
      wr_q    <= 1'b0;
      hd_q    <= 1'b0;
      bits_q  <= '0;
      mask_q  <= '0;
      valid_q <= 1'b0;
      beat_q  <= '0;
      sym_q   <= '0;
      flast_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      wr_q    <= wr_d;
      hd_q    <= hd_d;
      bits_q  <= bits_d;
      mask_q  <= mask_d;
      valid_q <= valid_d;
      beat_q  <= beat_d;
      sym_q   <= sym_d;
      flast_q <= flast_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wen) begin
      sre_q[wr_q] <= in_re;
      sim_q[wr_q] <= in_im;
      msk_q[wr_q] <= eq_valid_i;
    end
  end

`ifdef EQ_DEMAP_DROPCNT_EN
  logic [7:0] drop_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drop_q <= '0;
    end else if (drop && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 8'd1;
    end
  end
  assign drop_cnt_o = drop_q;
`else
  logic unused_drop;
  assign unused_drop = drop;
  assign drop_cnt_o  = '0;
`endif

  assign bits_o       = bits_q;
  assign lane_mask_o  = mask_q;
  assign bits_valid_o = valid_q;
  assign beat_idx_o   = beat_q;
  assign sym_idx_o    = sym_q;
  assign frame_last_o = flast_q;
  assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_eq_qpsk_demapper.sv
// Directed-vector bench for eq_qpsk_demapper at default parameters.
module tb_eq_qpsk_demapper;

  logic          clk;
  logic          rst;
  logic [2047:0] eq_datare, eq_dataim;
  logic [63:0]   eq_valid;
  logic          m_ready;
  logic [31:0]   bits;
  logic [15:0]   lane_mask;
  logic          bits_valid;
  logic [1:0]    beat_idx;
  logic [3:0]    sym_idx;
  logic          frame_last;
  logic          overflow;
  logic [7:0]    drop_cnt;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [63:0] VMASK = 64'hFFFF_FFC0_07FF_FFFE;
  localparam logic [31:0] POS1  = 32'h0400_0000;
  localparam logic [31:0] NEG1  = 32'hFC00_0000;

`ifdef EQ_DEMAP_DROPCNT_EN
  localparam logic [7:0] DROP_EXP = 8'd1;
`else
  localparam logic [7:0] DROP_EXP = 8'd0;
`endif

  eq_qpsk_demapper dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .eq_datare_i  (eq_datare),
    .eq_dataim_i  (eq_dataim),
    .eq_valid_i   (eq_valid),
    .m_ready_i    (m_ready),
    .bits_o       (bits),
    .lane_mask_o  (lane_mask),
    .bits_valid_o (bits_valid),
    .beat_idx_o   (beat_idx),
    .sym_idx_o    (sym_idx),
    .frame_last_o (frame_last),
    .overflow_o   (overflow),
    .drop_cnt_o   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_uniform(input logic [31:0] re, input logic [31:0] im, input logic [63:0] vld);
    for (int k = 0; k < 64; k++) begin
      eq_datare[k*32 +: 32] = re;
      eq_dataim[k*32 +: 32] = im;
    end
    eq_valid = vld;
  endtask

  // Odd carriers re=-1.0, even re=0; carriers 0-31 im=+1 LSB, 32-63 im=most negative.
  task automatic set_mixed();
    for (int k = 0; k < 64; k++) begin
      eq_datare[k*32 +: 32] = (k % 2 == 1) ? NEG1 : 32'h0;
      eq_dataim[k*32 +: 32] = (k >= 32) ? 32'h8000_0000 : 32'h0000_0001;
    end
    eq_valid = '1;
  endtask

  function automatic logic [31:0] mixed_bits(input int b);
    return (b < 2) ? 32'h4444_4444 : 32'hEEEE_EEEE;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    eq_valid = '0;
    m_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    eq_valid = '0;
    m_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    vectors++; if (bits !== 32'h0) begin miscompares++; $display("FAIL reset_bits: got %h expected 0", bits); end
    vectors++; if (lane_mask !== 16'h0) begin miscompares++; $display("FAIL reset_mask: got %h expected 0", lane_mask); end
    vectors++; if (bits_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", bits_valid); end
    vectors++; if (beat_idx !== 2'd0) begin miscompares++; $display("FAIL reset_beat: got %0d expected 0", beat_idx); end
    vectors++; if (sym_idx !== 4'd0) begin miscompares++; $display("FAIL reset_sym: got %0d expected 0", sym_idx); end
    vectors++; if (frame_last !== 1'b0) begin miscompares++; $display("FAIL reset_flast: got %b expected 0", frame_last); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
    vectors++; if (drop_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_drop: got %0d expected 0", drop_cnt); end
  endtask

  task automatic test_single_demap();
    logic [31:0] eb [4];
    logic [15:0] em [4];
    eb[0] = 32'hAAAA_AAA8; em[0] = 16'hFFFE;
    eb[1] = 32'h002A_AAAA; em[1] = 16'h07FF;
    eb[2] = 32'hAAAA_A000; em[2] = 16'hFFC0;
    eb[3] = 32'hAAAA_AAAA; em[3] = 16'hFFFF;
    do_reset();
    m_ready = 1'b1;
    set_uniform(POS1, NEG1, VMASK);
    tick();
    eq_valid = '0;
    for (int b = 0; b < 4; b++) begin
      vectors++; if (bits_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid b%0d: got %b expected 1", b, bits_valid); end
      vectors++; if (beat_idx !== 2'(b)) begin miscompares++; $display("FAIL single_beat: got %0d expected %0d", beat_idx, b); end
      vectors++; if (bits !== eb[b]) begin miscompares++; $display("FAIL single_bits b%0d: got %h expected %h", b, bits, eb[b]); end
      vectors++; if (lane_mask !== em[b]) begin miscompares++; $display("FAIL single_mask b%0d: got %h expected %h", b, lane_mask, em[b]); end
      tick();
    end
    vectors++; if (bits_valid !== 1'b0) begin miscompares++; $display("FAIL single_idle: got %b expected 0", bits_valid); end
    vectors++; if (sym_idx !== 4'd1) begin miscompares++; $display("FAIL single_symidx: got %0d expected 1", sym_idx); end
  endtask

  task automatic test_backpressure();
    do_reset();
    m_ready = 1'b1;
    set_uniform(POS1, NEG1, VMASK);
    tick();
    eq_valid = '0;
    tick();
    tick();
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vectors++; if (bits_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid c%0d: got %b expected 1", i, bits_valid); end
      vectors++; if (beat_idx !== 2'd2) begin miscompares++; $display("FAIL bp_beat c%0d: got %0d expected 2", i, beat_idx); end
      vectors++; if (bits !== 32'hAAAA_A000) begin miscompares++; $display("FAIL bp_bits c%0d: got %h expected aaaaa000", i, bits); end
      vectors++; if (lane_mask !== 16'hFFC0) begin miscompares++; $display("FAIL bp_mask c%0d: got %h expected ffc0", i, lane_mask); end
      if (i < 3) tick();
    end
    m_ready = 1'b1;
    tick();
    vectors++; if (beat_idx !== 2'd3 || bits !== 32'hAAAA_AAAA) begin miscompares++; $display("FAIL bp_beat3: got %0d/%h expected 3/aaaaaaaa", beat_idx, bits); end
    tick();
    vectors++; if (bits_valid !== 1'b0) begin miscompares++; $display("FAIL bp_end: got %b expected 0", bits_valid); end
  endtask

  task automatic test_full_rate_frame();
    int n = 0;
    do_reset();
    m_ready = 1'b1;
    for (int c = 0; c < 70; c++) begin
      if (c % 5 == 0 && c < 60) set_mixed();
      else eq_valid = '0;
      tick();
      if (bits_valid) begin
        vectors++; if (beat_idx !== 2'(n % 4) || sym_idx !== 4'(n / 4)) begin miscompares++; $display("FAIL frame_idx n%0d: got %0d/%0d expected %0d/%0d", n, beat_idx, sym_idx, n % 4, n / 4); end
        vectors++; if (bits !== mixed_bits(n % 4)) begin miscompares++; $display("FAIL frame_bits n%0d: got %h expected %h", n, bits, mixed_bits(n % 4)); end
        vectors++; if (frame_last !== (n == 47)) begin miscompares++; $display("FAIL frame_last n%0d: got %b expected %b", n, frame_last, (n == 47)); end
        n++;
      end else begin
        vectors++; if (frame_last !== 1'b0) begin miscompares++; $display("FAIL frame_last_idle c%0d: got %b expected 0", c, frame_last); end
      end
    end
    vectors++; if (n != 48) begin miscompares++; $display("FAIL frame_beats: got %0d expected 48", n); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL frame_ovf: got %b expected 0", overflow); end
    vectors++; if (sym_idx !== 4'd0) begin miscompares++; $display("FAIL frame_wrap: got %0d expected 0", sym_idx); end
  endtask

  task automatic test_overflow();
    int n = 0;
    logic [31:0] exp;
    do_reset();
    set_uniform(POS1, NEG1, '1);
    tick();
    set_mixed();
    tick();
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_early: got %b expected 0", overflow); end
    set_uniform(NEG1, POS1, '1);
    tick();
    eq_valid = '0;
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    vectors++; if (drop_cnt !== DROP_EXP) begin miscompares++; $display("FAIL ovf_dropcnt: got %0d expected %0d", drop_cnt, DROP_EXP); end
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bits_valid) begin
        exp = (n < 4) ? 32'hAAAA_AAAA : mixed_bits(n % 4);
        vectors++; if (bits !== exp || beat_idx !== 2'(n % 4)) begin miscompares++; $display("FAIL ovf_drain n%0d: got %h/%0d expected %h/%0d", n, bits, beat_idx, exp, n % 4); end
        n++;
      end
      tick();
    end
    vectors++; if (n != 8) begin miscompares++; $display("FAIL ovf_beats: got %0d expected 8", n); end
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
  endtask

  task automatic test_simul_release_capture();
    logic [31:0] exp;
    do_reset();
    set_uniform(POS1, NEG1, '1);
    tick();
    set_mixed();
    tick();
    eq_valid = '0;
    m_ready = 1'b1;
    tick();
    tick();
    tick();
    vectors++; if (beat_idx !== 2'd3) begin miscompares++; $display("FAIL simul_pre: got %0d expected 3", beat_idx); end
    set_uniform(NEG1, POS1, '1);
    tick();
    eq_valid = '0;
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL simul_ovf: got %b expected 0", overflow); end
    for (int n = 0; n < 8; n++) begin
      exp = (n < 4) ? mixed_bits(n) : 32'h5555_5555;
      vectors++; if (bits_valid !== 1'b1 || beat_idx !== 2'(n % 4)) begin miscompares++; $display("FAIL simul_seq n%0d: got %b/%0d expected 1/%0d", n, bits_valid, beat_idx, n % 4); end
      vectors++; if (bits !== exp || sym_idx !== 4'(1 + n / 4)) begin miscompares++; $display("FAIL simul_data n%0d: got %h/%0d expected %h/%0d", n, bits, sym_idx, exp, 1 + n / 4); end
      tick();
    end
    vectors++; if (bits_valid !== 1'b0) begin miscompares++; $display("FAIL simul_end: got %b expected 0", bits_valid); end
  endtask

  task automatic test_midstream_reset();
    do_reset();
    m_ready = 1'b1;
    set_uniform(POS1, NEG1, '1);
    tick();
    eq_valid = '0;
    tick();
    vectors++; if (beat_idx !== 2'd1) begin miscompares++; $display("FAIL mr_pre: got %0d expected 1", beat_idx); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++; if (bits !== 32'h0 || lane_mask !== 16'h0) begin miscompares++; $display("FAIL mr_data: got %h/%h expected 0/0", bits, lane_mask); end
    vectors++; if (bits_valid !== 1'b0 || beat_idx !== 2'd0 || sym_idx !== 4'd0) begin miscompares++; $display("FAIL mr_ctl: got %b/%0d/%0d expected 0/0/0", bits_valid, beat_idx, sym_idx); end
    vectors++; if (frame_last !== 1'b0 || overflow !== 1'b0 || drop_cnt !== 8'd0) begin miscompares++; $display("FAIL mr_flags: got %b/%b/%0d expected 0/0/0", frame_last, overflow, drop_cnt); end
    tick();
    tick();
    vectors++; if (bits_valid !== 1'b0) begin miscompares++; $display("FAIL mr_empty: got %b expected 0", bits_valid); end
    set_mixed();
    tick();
    eq_valid = '0;
    vectors++; if (bits_valid !== 1'b1 || beat_idx !== 2'd0 || sym_idx !== 4'd0) begin miscompares++; $display("FAIL mr_restart: got %b/%0d/%0d expected 1/0/0", bits_valid, beat_idx, sym_idx); end
    vectors++; if (bits !== 32'h4444_4444) begin miscompares++; $display("FAIL mr_bits: got %h expected 44444444", bits); end
  endtask

  initial begin
    rst = 1'b1;
    eq_datare = '0;
    eq_dataim = '0;
    eq_valid = '0;
    m_ready = 1'b0;
    test_reset();
    test_single_demap();
    test_backpressure();
    test_full_rate_frame();
    test_overflow();
    test_simul_release_capture();
    test_midstream_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
